tdm_mux_8x1: RTL and testbench
==============================

# tdm_mux_8x1

Eight-source round-robin multiplexer with valid/ready handshakes. It collects data from eight independent producers, one per channel, and serialises it onto a single output stream. Each output word carries a 3-bit channel tag, `out_sel`, which the downstream `demux_1x8` select input consumes directly. It is the sending end of the 1x8 demux path: one merged stream in front of the demux fabric, fair to all eight channels, with one word of buffering per channel.

## Interface
- `DW`, default 1: data width per channel in bits (legal 1..32).

- `clk` input 1: single clock; everything samples on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: block enable. Low means no new accepts and no new output loads.
- `in_valid` input 8: bit i means channel i is offering data.
- `in_data` input 8*DW: channel i data is `in_data[i*DW +: DW]`.
- `in_ready` output 8: bit i means channel i's buffer can accept a word.
- `out_valid` output 1: the output register holds a word.
- `out_data` output DW: the output word.
- `out_sel` output 3: source channel index of `out_data`.
- `out_ready` input 1: the downstream consumer accepts the word.

## Operation
- **Per-channel buffer.** Each channel has one entry: `full[i]` plus `buf[i]`.
  - `in_ready[i] = en & ~full[i]`. This is combinational from registered state and the `en` pin.
  - A word is accepted when `in_valid[i] & in_ready[i]` at a clock edge. The edge stores `in_data` into `buf[i]` and sets `full[i]`.
- **Round-robin pointer.** `ptr[2:0]` names the highest-priority channel.
  - Candidate search order is `ptr, ptr+1, ..., ptr+7`, mod 8.
  - The first channel with `full` set is the grant `g`.
- **Output load.** Load condition: `en & (|full) & (~out_valid | out_ready)`. On that edge:
  - `out_data <= buf[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `full[g] <= 0`.
  - `ptr <= g+1` (mod 8; 7 wraps to 0).
- **Drain without reload.** If `out_valid & out_ready` and the load condition is false, `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- **Backpressure.** While `out_valid & ~out_ready`, `out_valid`, `out_data` and `out_sel` are held stable. No `full` flag is cleared and `ptr` does not change.
- **Same-cycle events.**
  - A channel freed at edge N is not ready again until after edge N, because `in_ready` is registered-based.
  - No channel can be accepted and granted in the same cycle.
- **Disable (`en` = 0).**
  - All `in_ready` are 0 and no loads occur.
  - A word already in the output register still completes its handshake; `out_valid` drops on `out_ready`.
  - Buffered words are retained. When `en` returns, service resumes from the current `ptr`.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_sel=0`.
  - `ptr=0` and all `full=0`.
  - `in_ready = {8{en}}` immediately after reset.
  - Reset asserted mid-transfer discards all buffered and output words within the same cycle; no partial word appears after release.
- **Latency:** accept at edge N produces `out_valid`=1 after edge N+1 if the output register is free. The minimum is 2 edges from `in_valid` sampled to `out_valid` seen.
- **Throughput:**
  - Aggregate: one word per cycle while at least one channel is full and `out_ready`=1.
  - Per channel: at most one word every 2 cycles.
- **Fairness:** a full channel is granted within 8 output transfers at most.
- **Combinational paths:** there is no combinational path from `in_*` or `out_ready` to `out_*`. `out_ready` affects state only.

## Test plan
1. Reset then idle, `en`=1, DW=8.
   - After `rst` drop: `out_valid`=0, `out_sel`=0, `in_ready`=8'hFF.
   - Assert `rst` while `out_valid`=1: `out_valid`=0 in the same cycle, with no edge needed.
2. Single channel, `out_ready`=1. Channel 3 offers 8'hA5 for one cycle at edge N.
   - After edge N+1: `out_valid`=1, `out_sel`=3, `out_data`=8'hA5.
   - `in_ready[3]` is 0 for exactly 1 cycle.
3. All channels at once, `out_ready`=1, `ptr`=0. Channel i offers 8'h10+i for one cycle.
   - Output is 8 consecutive valid cycles with `out_sel` 0,1,...,7 and `out_data` 8'h10..8'h17.
   - `ptr` ends at 0.
4. Fairness. Channels 2 and 5 hold `in_valid` high continuously with `out_ready`=1.
   - `out_sel` alternates 2,5,2,5 and no channel is granted twice in a row.
5. Backpressure. `out_ready`=0 for 5 cycles with channels 1 and 6 full.
   - `out_valid`, `out_data` and `out_sel` are stable, `in_ready[1]`=`in_ready[6]`=0, and `ptr` is unchanged.
   - Raise `out_ready`: one word transfers per cycle, in round-robin order.
6. Enable gating. Channels 0 and 4 are full and one word is in the output register; drop `en`.
   - The pending word transfers on `out_ready`, then `out_valid`=0 and `in_ready`=0.
   - Raise `en`: channel 0 then 4 are emitted if `ptr`≤0, otherwise per `ptr` order.

Source files
------------

// File: rtl/tdm_mux_8x1.sv
// tdm_mux_8x1: eight-channel round-robin merger with one word of buffering
// per channel. The merged stream carries a 3-bit channel tag (out_sel) for
// the downstream 1x8 demux.
//
// Handshake semantics, input and output sides alike: a word moves on a rising
// clock edge exactly when valid and ready are both high at that edge. While
// valid is high and ready is low, the producer holds its word and valid stable.
// in_ready is derived only from registered state and en. out_ready only
// affects state, so no input reaches out_* through combinational logic.
module tdm_mux_8x1 #(
  parameter int DW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [7:0]      in_valid,
  input  logic [8*DW-1:0] in_data,
  output logic [7:0]      in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [2:0]      out_sel,
  input  logic            out_ready
);

  logic [7:0]    full;
  logic [DW-1:0] data_buf [8];
  logic [2:0]    ptr;

  logic [2:0]    grant;
  logic          grant_found;
  logic          load;
  logic [7:0]    accept;
  logic [7:0]    clear_mask;

  // A channel can take a word only while its single buffer entry is empty.
  assign in_ready = {8{en}} & ~full;
  assign accept   = in_valid & in_ready;

  // Round-robin search: the first full channel at or after ptr wins.
  always_comb begin
    grant       = ptr;
    grant_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!grant_found && full[ptr + 3'(k)]) begin
        grant       = ptr + 3'(k);
        grant_found = 1'b1;
      end
    end
  end

  // Load the output register when something is buffered and it is free or draining.
  assign load       = en & (|full) & (~out_valid | out_ready);
  assign clear_mask = load ? (8'b1 << grant) : 8'b0;

  // Buffer entries, round-robin pointer and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 8'b0;
      ptr       <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        data_buf[i] <= '0;
      end
    end else begin
      // A full channel is never ready, so accept and clear never hit the same bit.
      for (int i = 0; i < 8; i++) begin
        if (accept[i]) begin
          data_buf[i] <= in_data[i*DW +: DW];
        end
      end
      full <= (full & ~clear_mask) | accept;

      if (load) begin
        out_data  <= data_buf[grant];
        out_sel   <= grant;
        out_valid <= 1'b1;
        ptr       <= grant + 3'd1;
      end else if (out_valid && out_ready) begin
        // Drained with nothing to follow: data and tag keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// tb_tdm_mux_8x1: directed vectors for the round-robin 8x1 merger at DW=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_tdm_mux_8x1;

  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic            en;
  logic [7:0]      in_valid;
  logic [8*DW-1:0] in_data;
  logic [7:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_sel;
  logic            out_ready;

  int n_checks;
  int n_fail;

  // Expected output words, {sel, data}.
  logic [DW+2:0] exp_q[$];

  tdm_mux_8x1 #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Checker: every comparison goes through here.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: offer one word on channel ch (does not clear other channels).
  task automatic offer(input int ch, input logic [DW-1:0] d);
    in_valid[ch]          = 1'b1;
    in_data[ch*DW +: DW]  = d;
  endtask

  // Scoreboard: compare the current output word against the queue head.
  task automatic check_head(input string tag);
    logic [DW+2:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_sel"},   {29'd0, out_sel},   {29'd0, e[DW+2:DW]});
      check({tag, "_data"},  {24'd0, out_data},  {24'd0, e[DW-1:0]});
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    en        = 1'b1;
    out_ready = 1'b1;
    in_valid  = 8'h00;
    in_data   = '0;

    // 1. Reset then idle.
    do_reset();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sel",   {29'd0, out_sel},   32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_in_ready",  {24'd0, in_ready},  32'hFF);

    // 2. Single channel 3, value A5.
    offer(3, 8'hA5);
    tick();                                   // edge N: accepted
    in_valid = 8'h00;
    check("t2_ready3_low", {31'd0, in_ready[3]}, 32'd0);
    check("t2_no_out_yet", {31'd0, out_valid},   32'd0);
    tick();                                   // edge N+1: loaded
    check("t2_valid", {31'd0, out_valid},   32'd1);
    check("t2_sel",   {29'd0, out_sel},     32'd3);
    check("t2_data",  {24'd0, out_data},    32'hA5);
    check("t2_ready3_back", {31'd0, in_ready[3]}, 32'd1);

    // Reset asserted while out_valid=1 clears it without a clock edge.
    rst = 1'b1;
    #1;
    check("t1_async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t1_async_rst_ready", {24'd0, in_ready},  32'hFF);
    tick();
    rst = 1'b0;
    #1;

    // 3. All channels at once from ptr=0.
    for (int i = 0; i < 8; i++) begin
      offer(i, 8'h10 + 8'(i));
      exp_q.push_back({3'(i), 8'h10 + 8'(i)});
    end
    tick();
    in_valid = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_head("t3");
    end
    tick();
    check("t3_drained", {31'd0, out_valid}, 32'd0);

    // 4. Fairness: channels 2 and 5 held valid. ptr ended at 0, so 2 goes first.
    offer(2, 8'h22);
    offer(5, 8'h55);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({3'd2, 8'h22});
      exp_q.push_back({3'd5, 8'h55});
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      check_head("t4");
    end
    do_reset();

    // 5. Backpressure with channels 1 and 6 full.
    out_ready = 1'b0;
    offer(1, 8'h31);
    offer(6, 8'h36);
    tick();                                   // accept 1 and 6
    in_data[1*DW +: DW] = 8'h41;
    tick();                                   // load 1 (ptr=2), re-accept ch1 next edge
    tick();                                   // ch1 holds 0x41
    in_valid = 8'h00;
    for (int k = 0; k < 5; k++) begin
      check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t5_hold_sel",   {29'd0, out_sel},   32'd1);
      check("t5_hold_data",  {24'd0, out_data},  32'h31);
      check("t5_ready1",     {31'd0, in_ready[1]}, 32'd0);
      check("t5_ready6",     {31'd0, in_ready[6]}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    exp_q.push_back({3'd6, 8'h36});
    exp_q.push_back({3'd1, 8'h41});
    tick();
    check_head("t5");
    tick();
    check_head("t5");
    tick();
    check("t5_drained", {31'd0, out_valid}, 32'd0);

    // 6. Enable gating: ch7 in output register, channels 0 and 4 buffered.
    do_reset();
    out_ready = 1'b0;
    offer(7, 8'hA7);
    tick();                                   // accept 7
    in_valid = 8'h00;
    offer(0, 8'hA0);
    offer(4, 8'hA4);
    tick();                                   // load 7 (ptr=0), accept 0 and 4
    in_valid = 8'h00;
    en = 1'b0;
    #1;
    check("t6_ready_off", {24'd0, in_ready}, 32'h00);
    check("t6_pending",   {29'd0, out_sel},  32'd7);
    out_ready = 1'b1;
    tick();
    check("t6_drain_valid", {31'd0, out_valid}, 32'd0);
    check("t6_drain_sel",   {29'd0, out_sel},   32'd7);
    check("t6_drain_data",  {24'd0, out_data},  32'hA7);
    tick();
    check("t6_idle_valid", {31'd0, out_valid}, 32'd0);
    check("t6_idle_ready", {24'd0, in_ready},  32'h00);
    en = 1'b1;
    #1;
    check("t6_ready_on", {24'd0, in_ready}, 32'hEE);
    exp_q.push_back({3'd0, 8'hA0});
    exp_q.push_back({3'd4, 8'hA4});
    tick();
    check_head("t6");
    tick();
    check_head("t6");
    tick();
    check("t6_end_valid", {31'd0, out_valid}, 32'd0);
    check("t6_end_ready", {24'd0, in_ready},  32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
